// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle control unit:
// FSM states, PC/regdst selects, ALU ops, opcodes and the decoded ctrl bundle.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALTED
  } state_t;

  typedef enum logic [1:0] {
    PLUS4, BRANCH, JUMP, JR
  } pcsel_t;

  typedef enum logic [1:0] {
    RD, RT, R31
  } regdst_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ADDIU = 6'b001001,
    OP_SLTI  = 6'b001010,
    OP_SLTIU = 6'b001011,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_LBU   = 6'b100100,
    OP_LHU   = 6'b100101,
    OP_SB    = 6'b101000,
    OP_SH    = 6'b101001,
    OP_SW    = 6'b101011,
    OP_LL    = 6'b110000,
    OP_SC    = 6'b111000,
    OP_HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    F_SLL  = 6'b000000,
    F_SRL  = 6'b000010,
    F_JR   = 6'b001000,
    F_ADD  = 6'b100000,
    F_ADDU = 6'b100001,
    F_SUB  = 6'b100010,
    F_SUBU = 6'b100011,
    F_AND  = 6'b100100,
    F_OR   = 6'b100101,
    F_XOR  = 6'b100110,
    F_NOR  = 6'b100111,
    F_SLT  = 6'b101010,
    F_SLTU = 6'b101011
  } funct_t;

  // Instruction class steering the FSM path.
  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_LW, K_SW, K_LL, K_SC,
    K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_HALT
  } kind_t;

  typedef struct packed {
    kind_t   kind;
    aluop_t  alu_op;
    regdst_t reg_dst;
    logic    alu_src;
    logic    shamt_en;
    logic    sign_ext;
    logic    lui;
    logic    ovf_chk;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decoder: opcode/funct -> ctrl_t bundle.
// Ports: op, funct in; ctrl out. Unsupported ops decode as K_NOP.
module mc_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  logic imm;

  always_comb begin
    ctrl = '0;
    imm  = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl.kind    = K_ALU;
        ctrl.reg_dst = RD;
        unique case (1'b1)
          funct == F_ADD: begin
            ctrl.alu_op  = ALU_ADD;
            ctrl.ovf_chk = 1'b1;
          end
          funct == F_ADDU: ctrl.alu_op = ALU_ADD;
          funct == F_SUB: begin
            ctrl.alu_op  = ALU_SUB;
            ctrl.ovf_chk = 1'b1;
          end
          funct == F_SUBU: ctrl.alu_op = ALU_SUB;
          funct == F_AND:  ctrl.alu_op = ALU_AND;
          funct == F_OR:   ctrl.alu_op = ALU_OR;
          funct == F_XOR:  ctrl.alu_op = ALU_XOR;
          funct == F_NOR:  ctrl.alu_op = ALU_NOR;
          funct == F_SLT:  ctrl.alu_op = ALU_SLT;
          funct == F_SLTU: ctrl.alu_op = ALU_SLTU;
          funct == F_SLL: begin
            ctrl.alu_op   = ALU_SLL;
            ctrl.shamt_en = 1'b1;
          end
          funct == F_SRL: begin
            ctrl.alu_op   = ALU_SRL;
            ctrl.shamt_en = 1'b1;
          end
          funct == F_JR: ctrl.kind = K_JR;
          default: ctrl.kind = K_NOP;
        endcase
      end
      op == OP_ADDI: begin
        ctrl.kind     = K_ALU;
        ctrl.alu_op   = ALU_ADD;
        ctrl.sign_ext = 1'b1;
        ctrl.ovf_chk  = 1'b1;
        imm           = 1'b1;
      end
      op == OP_ADDIU: begin
        ctrl.kind     = K_ALU;
        ctrl.alu_op   = ALU_ADD;
        ctrl.sign_ext = 1'b1;
        imm           = 1'b1;
      end
      op == OP_SLTI: begin
        ctrl.kind     = K_ALU;
        ctrl.alu_op   = ALU_SLT;
        ctrl.sign_ext = 1'b1;
        imm           = 1'b1;
      end
      op == OP_SLTIU: begin
        ctrl.kind     = K_ALU;
        ctrl.alu_op   = ALU_SLTU;
        ctrl.sign_ext = 1'b1;
        imm           = 1'b1;
      end
      op == OP_ANDI: begin
        ctrl.kind   = K_ALU;
        ctrl.alu_op = ALU_AND;
        imm         = 1'b1;
      end
      op == OP_ORI: begin
        ctrl.kind   = K_ALU;
        ctrl.alu_op = ALU_OR;
        imm         = 1'b1;
      end
      op == OP_XORI: begin
        ctrl.kind   = K_ALU;
        ctrl.alu_op = ALU_XOR;
        imm         = 1'b1;
      end
      op == OP_LUI: begin
        ctrl.kind   = K_ALU;
        ctrl.alu_op = ALU_OR;
        ctrl.lui    = 1'b1;
        imm         = 1'b1;
      end
      op == OP_LW: begin
        ctrl.kind = K_LW;
        imm       = 1'b1;
      end
      op == OP_LL: begin
        ctrl.kind = K_LL;
        imm       = 1'b1;
      end
      op == OP_SW: begin
        ctrl.kind = K_SW;
        imm       = 1'b1;
      end
      op == OP_SC: begin
        ctrl.kind = K_SC;
        imm       = 1'b1;
      end
      op == OP_BEQ: begin
        ctrl.kind     = K_BEQ;
        ctrl.alu_op   = ALU_SUB;
        ctrl.sign_ext = 1'b1;
      end
      op == OP_BNE: begin
        ctrl.kind     = K_BNE;
        ctrl.alu_op   = ALU_SUB;
        ctrl.sign_ext = 1'b1;
      end
      op == OP_J:    ctrl.kind = K_J;
      op == OP_JAL: begin
        ctrl.kind    = K_JAL;
        ctrl.reg_dst = R31;
      end
      op == OP_HALT: ctrl.kind = K_HALT;
      default: ctrl.kind = K_NOP;
    endcase
    // Memory ops form their address as base + signed offset.
    unique case (ctrl.kind)
      K_LW, K_LL, K_SW, K_SC: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.sign_ext = 1'b1;
        ctrl.ovf_chk  = 1'b1;
      end
      default: ;
    endcase
    if (imm) begin
      ctrl.alu_src = 1'b1;
      ctrl.reg_dst = RT;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with LL/SC link, overflow trap and bus watchdog.
// Ports: bus handshakes (ihit/dhit), ALU flags/address, snoop in; strobes/muxes out.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          LINK_EN     = 1'b1,
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              ir_load,
  output logic              pc_en,
  output pcsel_t            pc_sel,
  output logic              reg_wen,
  output regdst_t           reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src,
  output logic              shamt_en,
  output logic              sign_ext,
  output logic              lui,
  output aluop_t            alu_op,
  output logic              sc_result,
  output logic              halt,
  output logic              bus_error,
  output state_t            state
);

  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TO_LAST = TW'(BUS_TIMEOUT - 1);

  state_t              state_n;
  ctrl_t               dec_ctrl;
  ctrl_t               ctrl_q;
  logic                link_valid;
  logic [ADDR_W-1:0]   link_addr;
  logic [TW-1:0]       timer;
  logic                sc_ok;
  logic                waiting;
  logic                timeout;
  logic                snoop_hit;
  logic                link_hit;
  logic                ll_done;
  logic                sc_exit;
  logic                is_load;
  logic                is_store;
  logic                unused_instr;

  assign unused_instr = ^instr;

  mc_decode u_dec (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .ctrl  (dec_ctrl)
  );

  assign is_load  = ctrl_q.kind == K_LW
                 || ctrl_q.kind == K_LL;
  assign is_store = ctrl_q.kind == K_SW
                 || ctrl_q.kind == K_SC;

  // A snoop in the same cycle as an SC check kills the link first.
  assign snoop_hit = snoop_valid
                  && snoop_addr == link_addr;
  assign link_hit  = LINK_EN && link_valid
                  && link_addr == alu_addr
                  && !snoop_hit;

  assign ll_done = state == MEM && dhit
                && ctrl_q.kind == K_LL;
  assign sc_exit = state == EXEC
                && ctrl_q.kind == K_SC;

  assign waiting = (state == FETCH && !ihit)
                || (state == MEM && !dhit);
  assign timeout = BUS_TIMEOUT != 0 && waiting
                && timer == TO_LAST;

  assign halt = state == HALTED;

  always_comb begin
    state_n    = state;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = PLUS4;
    reg_wen    = 1'b0;
    reg_dst    = RD;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    shamt_en   = 1'b0;
    sign_ext   = 1'b0;
    lui        = 1'b0;
    alu_op     = ALU_SLL;
    sc_result  = 1'b0;
    // The address must stay valid through MEM for the link capture.
    if (state == EXEC || state == MEM) begin
      alu_op   = ctrl_q.alu_op;
      alu_src  = ctrl_q.alu_src;
      shamt_en = ctrl_q.shamt_en;
      sign_ext = ctrl_q.sign_ext;
      lui      = ctrl_q.lui;
    end
    unique case (state)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_load = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        pc_en = 1'b1;
        if (ctrl_q.kind == K_HALT)
          state_n = HALTED;
        else
          state_n = EXEC;
      end
      EXEC: begin
        state_n = FETCH;
        if (ctrl_q.ovf_chk && alu_overflow) begin
          state_n = HALTED;
        end else begin
          unique case (ctrl_q.kind)
            K_BEQ: begin
              pc_en  = alu_zero;
              pc_sel = BRANCH;
            end
            K_BNE: begin
              pc_en  = !alu_zero;
              pc_sel = BRANCH;
            end
            K_J: begin
              pc_en  = 1'b1;
              pc_sel = JUMP;
            end
            K_JR: begin
              pc_en  = 1'b1;
              pc_sel = JR;
            end
            K_JAL: begin
              pc_en   = 1'b1;
              pc_sel  = JUMP;
              state_n = WB;
            end
            K_LW, K_LL, K_SW: state_n = MEM;
            K_SC: state_n = link_hit ? MEM : WB;
            K_ALU: state_n = WB;
            default: state_n = FETCH;
          endcase
        end
      end
      MEM: begin
        dREN = is_load;
        dWEN = is_store;
        if (dhit) begin
          if (ctrl_q.kind == K_SW)
            state_n = FETCH;
          else
            state_n = WB;
        end
      end
      WB: begin
        reg_wen    = 1'b1;
        reg_dst    = ctrl_q.reg_dst;
        mem_to_reg = is_load;
        sc_result  = ctrl_q.kind == K_SC && sc_ok;
        state_n    = FETCH;
      end
      HALTED: state_n = HALTED;
      default: state_n = FETCH;
    endcase
    if (timeout) state_n = HALTED;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      ctrl_q     <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      timer      <= '0;
      sc_ok      <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state <= state_n;
      // Capture decode alongside the IR so a changing port is harmless.
      if (state == FETCH && ihit) ctrl_q <= dec_ctrl;
      // LL completion beats a coincident snoop.
      if (ll_done) begin
        link_valid <= LINK_EN;
        link_addr  <= alu_addr;
      end else if (sc_exit || snoop_hit) begin
        link_valid <= 1'b0;
      end
      if (sc_exit) sc_ok <= link_hit;
      if (waiting && BUS_TIMEOUT != 0)
        timer <= timer + 1'b1;
      else
        timer <= '0;
      if (timeout) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: u_a default params, u_b with LINK_EN=0 and BUS_TIMEOUT=8.
// Both see the same stimulus; expected values are hand-derived.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0000;
  localparam logic [31:0] I_SW   = 32'hAC22_0000;
  localparam logic [31:0] I_LL   = 32'hC022_0000;
  localparam logic [31:0] I_SC   = 32'hE023_0000;
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;
  localparam logic [31:0] I_BNE  = 32'h1422_0004;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_SB   = 32'hA022_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] instr = '0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_overflow = 1'b0;
  logic [31:0] alu_addr = 32'h100;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = 32'h100;

  logic a_iren, a_dren, a_dwen, a_irl, a_pcen, a_wen;
  logic a_m2r, a_asrc, a_sh, a_sx, a_lui, a_sc;
  logic a_halt, a_berr;
  pcsel_t a_psel;
  regdst_t a_rdst;
  aluop_t a_aop;
  state_t a_st;

  logic b_iren, b_dren, b_dwen, b_irl, b_pcen, b_wen;
  logic b_m2r, b_asrc, b_sh, b_sx, b_lui, b_sc;
  logic b_halt, b_berr;
  pcsel_t b_psel;
  regdst_t b_rdst;
  aluop_t b_aop;
  state_t b_st;

  int n_chk = 0;
  int n_pass = 0;

  int na_dren, na_dwen, na_wen, na_pcen, na_irl;
  int na_both, nb_dwen, nb_wen, nb_iren;
  logic sa_sc, sb_sc, la_m2r;
  pcsel_t la_psel;
  regdst_t la_rdst;

  always #5 CLK = ~CLK;

  multicycle_control_unit u_a (
    .CLK(CLK), .nRST(nRST), .instr(instr),
    .ihit(ihit), .dhit(dhit),
    .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .alu_addr(alu_addr),
    .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr),
    .iREN(a_iren), .dREN(a_dren), .dWEN(a_dwen),
    .ir_load(a_irl), .pc_en(a_pcen),
    .pc_sel(a_psel), .reg_wen(a_wen),
    .reg_dst(a_rdst), .mem_to_reg(a_m2r),
    .alu_src(a_asrc), .shamt_en(a_sh),
    .sign_ext(a_sx), .lui(a_lui),
    .alu_op(a_aop), .sc_result(a_sc),
    .halt(a_halt), .bus_error(a_berr),
    .state(a_st)
  );

  multicycle_control_unit #(
    .LINK_EN(1'b0), .BUS_TIMEOUT(8)
  ) u_b (
    .CLK(CLK), .nRST(nRST), .instr(instr),
    .ihit(ihit), .dhit(dhit),
    .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .alu_addr(alu_addr),
    .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr),
    .iREN(b_iren), .dREN(b_dren), .dWEN(b_dwen),
    .ir_load(b_irl), .pc_en(b_pcen),
    .pc_sel(b_psel), .reg_wen(b_wen),
    .reg_dst(b_rdst), .mem_to_reg(b_m2r),
    .alu_src(b_asrc), .shamt_en(b_sh),
    .sign_ext(b_sx), .lui(b_lui),
    .alu_op(b_aop), .sc_result(b_sc),
    .halt(b_halt), .bus_error(b_berr),
    .state(b_st)
  );

  function automatic logic [31:0] outs_a();
    return {7'd0, a_iren, a_dren, a_dwen, a_irl,
            a_pcen, a_psel, a_wen, a_rdst, a_m2r,
            a_asrc, a_sh, a_sx, a_lui, a_aop, a_sc,
            a_halt, a_berr, a_st};
  endfunction

  function automatic logic [31:0] outs_b();
    return {7'd0, b_iren, b_dren, b_dwen, b_irl,
            b_pcen, b_psel, b_wen, b_rdst, b_m2r,
            b_asrc, b_sh, b_sx, b_lui, b_aop, b_sc,
            b_halt, b_berr, b_st};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    step();
    nRST = 1'b0;
    ihit = 1'b0;
    dhit = 1'b0;
    snoop_valid = 1'b0;
    alu_zero = 1'b0;
    alu_overflow = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  // Runs n cycles, pulsing ihit/dhit/snoop on the given cycle numbers.
  task automatic run(input logic [31:0] ins,
                     input int n, input int ihit_at,
                     input int hit_at, input int snp_at,
                     input bit ihold);
    na_dren = 0; na_dwen = 0; na_wen = 0;
    na_pcen = 0; na_irl = 0; na_both = 0;
    nb_dwen = 0; nb_wen = 0; nb_iren = 0;
    sa_sc = 1'b0; sb_sc = 1'b0; la_m2r = 1'b0;
    la_psel = PLUS4; la_rdst = RD;
    instr = ins;
    for (int c = 1; c <= n; c++) begin
      ihit = ihold || c == ihit_at;
      dhit = c == hit_at;
      snoop_valid = c == snp_at;
      #1;
      na_dren += int'(a_dren);
      na_dwen += int'(a_dwen);
      na_wen  += int'(a_wen);
      na_pcen += int'(a_pcen);
      na_irl  += int'(a_irl);
      na_both += int'(a_pcen && a_wen);
      nb_dwen += int'(b_dwen);
      nb_wen  += int'(b_wen);
      nb_iren += int'(b_iren);
      if (a_wen) begin
        sa_sc   = sa_sc | a_sc;
        la_m2r  = a_m2r;
        la_rdst = a_rdst;
      end
      if (b_wen) sb_sc = sb_sc | b_sc;
      if (a_pcen && a_st == EXEC) la_psel = a_psel;
      step();
    end
    ihit = 1'b0;
    dhit = 1'b0;
    snoop_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_outs_a", outs_a(), 32'h0100_0000);
    check("rst_outs_b", outs_b(), 32'h0100_0000);

    // ADDU cycle by cycle.
    instr = I_ADDU;
    ihit = 1'b1;
    #1;
    check("addu_c1_irl", 32'(a_irl), 32'd1);
    step();
    ihit = 1'b0;
    check("addu_c2_st", 32'(a_st), 32'(DECODE));
    check("addu_c2_pc", {a_pcen, a_psel}, {1'b1, PLUS4});
    step();
    check("addu_c3_op", 32'(a_aop), 32'(ALU_ADD));
    step();
    check("addu_c4_wb", {a_wen, a_rdst, a_pcen},
          {1'b1, RD, 1'b0});
    step();
    check("addu_c5_st", 32'(a_st), 32'(FETCH));

    // LW, dhit three cycles late.
    run(I_LW, 8, 1, 7, 0, 1'b0);
    check("lw_dren", na_dren, 4);
    check("lw_wen", na_wen, 1);
    check("lw_m2r_rt", {la_m2r, la_rdst}, {1'b1, RT});
    check("lw_end_st", 32'(a_st), 32'(FETCH));

    // LL then SC to the same address.
    do_reset();
    run(I_LL, 5, 1, 4, 0, 1'b0);
    check("ll_dren", na_dren, 1);
    run(I_SC, 5, 1, 4, 0, 1'b0);
    check("sc_ok_res", 32'(sa_sc), 32'd1);
    check("sc_ok_dwen", na_dwen, 1);
    check("sc_ok_st", 32'(a_st), 32'(FETCH));
    check("nolink_res", 32'(sb_sc), 32'd0);
    check("nolink_dwen", nb_dwen, 0);
    check("nolink_wen", nb_wen, 1);
    // Link was consumed by the first SC.
    run(I_SC, 4, 1, 0, 0, 1'b0);
    check("sc2_res", {sa_sc, 31'(na_dwen)}, 32'd0);
    check("sc2_st", 32'(a_st), 32'(FETCH));

    // Snoop between LL and SC.
    do_reset();
    run(I_LL, 5, 1, 4, 0, 1'b0);
    run(I_SC, 4, 1, 0, 1, 1'b0);
    check("snp_res", 32'(sa_sc), 32'd0);
    check("snp_dwen", na_dwen, 0);
    check("snp_st", 32'(a_st), 32'(FETCH));

    // Snoop coincident with SC in EXEC.
    do_reset();
    run(I_LL, 5, 1, 4, 0, 1'b0);
    run(I_SC, 4, 1, 0, 3, 1'b0);
    check("snpex_res", {sa_sc, 31'(na_dwen)}, 32'd0);

    // Snoop coincident with LL dhit.
    do_reset();
    run(I_LL, 5, 1, 4, 4, 1'b0);
    run(I_SC, 5, 1, 4, 0, 1'b0);
    check("snpll_res", 32'(sa_sc), 32'd1);
    check("snpll_dwen", na_dwen, 1);

    // Control flow and stores.
    alu_zero = 1'b1;
    run(I_BEQ, 3, 1, 0, 0, 1'b0);
    check("beq_pcen", na_pcen, 2);
    check("beq_sel", 32'(la_psel), 32'(BRANCH));
    check("beq_st", 32'(a_st), 32'(FETCH));
    run(I_BNE, 3, 1, 0, 0, 1'b0);
    check("bne_pcen", na_pcen, 1);
    alu_zero = 1'b0;
    run(I_JAL, 4, 1, 0, 0, 1'b0);
    check("jal_pcen", na_pcen, 2);
    check("jal_sel", 32'(la_psel), 32'(JUMP));
    check("jal_wb", {na_wen[3:0], la_rdst}, {4'd1, R31});
    check("jal_both", na_both, 0);
    check("jal_st", 32'(a_st), 32'(FETCH));
    run(I_SW, 4, 1, 4, 0, 1'b0);
    check("sw_dwen_wen", {na_dwen[15:0], na_wen[15:0]},
          {16'd1, 16'd0});
    check("sw_st", 32'(a_st), 32'(FETCH));
    run(I_SB, 3, 1, 0, 0, 1'b0);
    check("sb_nop", na_wen + na_dwen + na_dren, 0);
    check("sb_st", 32'(a_st), 32'(FETCH));

    // Overflow trap.
    do_reset();
    alu_overflow = 1'b1;
    run(I_ADD, 3, 1, 0, 0, 1'b1);
    check("ovf_st", 32'(a_st), 32'(HALTED));
    check("ovf_halt", 32'(a_halt), 32'd1);
    check("ovf_wen", na_wen, 0);
    run(I_ADD, 4, 1, 0, 0, 1'b1);
    check("ovf_sticky", {a_halt, a_iren}, 2'b10);
    check("ovf_noirl", na_irl + na_wen, 0);
    alu_overflow = 1'b0;

    // Watchdog on u_b only.
    do_reset();
    run(I_ADDU, 8, 0, 0, 0, 1'b0);
    check("wd_iren_cyc", nb_iren, 8);
    check("wd_b_st", 32'(b_st), 32'(HALTED));
    check("wd_b_flags", {b_berr, b_halt, b_iren}, 3'b110);
    check("wd_a_idle", {a_st, a_berr}, {FETCH, 1'b0});

    // HALT then async reset clears everything.
    do_reset();
    check("rst_berr_b", 32'(b_berr), 32'd0);
    run(I_LL, 5, 1, 4, 0, 1'b0);
    run(I_HALT, 2, 1, 0, 0, 1'b0);
    check("halt_st", 32'(a_st), 32'(HALTED));
    nRST = 1'b0;
    #1;
    check("arst_outs", {a_st, a_iren, a_halt},
          {FETCH, 1'b1, 1'b0});
    #2;
    nRST = 1'b1;
    run(I_SC, 4, 1, 0, 0, 1'b0);
    check("arst_link", {sa_sc, 31'(na_dwen)}, 32'd0);
    check("arst_sc_st", 32'(a_st), 32'(FETCH));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
